muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit downstream of the ALU source-B mux; consumes SrcA (register RD1) and SrcB (mux output) in parallel with the ALU.
- Implements the MIPS MULT/MULTU/DIV/DIVU operations into HI/LO registers, plus MTHI/MTLO writes.
- Exposes busy so the control unit can stall MFHI/MFLO and further mult/div instructions while an operation is in flight.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. Only 32 is verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- SrcA  input  WIDTH  operand A (multiplicand or dividend); also the data for HiWrite/LoWrite.
- SrcB  input  WIDTH  operand B (multiplier or divisor), from the ALU source-B mux.
- Start  input  1  begin the operation selected by MDOp; sampled only in IDLE.
- MDOp  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- HiWrite  input  1  MTHI: HI <= SrcA.
- LoWrite  input  1  MTLO: LO <= SrcA.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse when HI/LO receive a result.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE; Hi=0; Lo=0; Busy=0; Done=0; iteration counter=0.
  - All operand and partial-result registers are cleared.
- FSM states: IDLE, CALC, FIX.
- IDLE, Start=1 at edge N:
  - Latch SrcA, SrcB, MDOp.
  - For signed ops, store absolute values and record the result signs.
  - Counter=0; go to CALC. Busy=1 from edge N onward.
- CALC: one iteration per edge, 32 edges (N+1..N+32). At edge N+32, go to FIX.
  - Multiply is radix-2 shift-add on magnitudes, producing a 64-bit product.
  - Divide is restoring, one quotient bit per edge, on magnitudes.
- FIX, edge N+33:
  - Apply sign correction and write Hi/Lo.
  - Done=1 for exactly one cycle; Busy=0; go to IDLE.
  - Results are visible after edge N+33, i.e. 33 cycles of Busy.
- Multiply results:
  - {Hi,Lo} is the full 64-bit product.
  - MULT treats operands as two's complement; MULTU as unsigned.
- Divide results:
  - Lo=quotient, Hi=remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide boundary cases:
  - Divide by zero (DIV or DIVU): Lo=0xFFFFFFFF, Hi=latched SrcA. No trap is raised.
  - DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0x00000000.
- Start, HiWrite and LoWrite while Busy=1 are ignored.
  - Operands are already latched, so changes on SrcA/SrcB during Busy have no effect.
- HiWrite/LoWrite in IDLE: Hi/Lo update at that edge. Both may be asserted together.
- Start together with HiWrite or LoWrite in IDLE: Start wins and the write is dropped.
- Start in the FIX cycle is ignored, because FIX is not IDLE.
  - A new Start is accepted at the earliest on the edge after the Done edge.
- Done stays low on MTHI/MTLO and on reset.
- Hi/Lo hold their values while Busy=1. There is no partial-result leakage.
- The control unit must stall while Busy=1. This block does not forward results.

Test Plan:
- MULTU: SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF, Start at edge N → Busy high for edges N..N+32; at N+33 Hi=0xFFFFFFFE, Lo=0x00000001, Done=1 for one cycle.
- MULT: SrcA=0xFFFFFFFD (-3), SrcB=7 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21). MULT 0x80000000×0x80000000 → Hi=0x40000000, Lo=0.
- Divide:
  - DIVU 100/7 → Lo=14, Hi=2.
  - DIV 0xFFFFFFF9 (-7) / 2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - DIV 7 / 0xFFFFFFFE (-2) → Lo=0xFFFFFFFD, Hi=1.
- Divide boundaries:
  - DIV 0x12345678/0 → Lo=0xFFFFFFFF, Hi=0x12345678.
  - DIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0.
- During a MULTU 3×5: assert Start with DIVU 9/3, pulse HiWrite with SrcA=0xDEADBEEF, and change SrcA/SrcB at cycle 10 → all ignored; final Hi=0, Lo=15, single Done pulse.
- Reset asserted asynchronously at CALC cycle 12 (mid-clock) → Hi/Lo/Busy/Done=0 immediately. After release, LoWrite with SrcA=0x55 → Lo=0x55, Done stays 0. Then MULTU 6×7 completes with Lo=42.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes; sign fixed up in a final cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Start,
  input  logic [1:0]       MDOp,
  input  logic             HiWrite,
  input  logic             LoWrite,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shl, div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // Operand magnitudes; MDOp[0] set means unsigned
    sgn_op = ~MDOp[0];
    a_neg  = sgn_op & SrcA[WIDTH-1];
    b_neg  = sgn_op & SrcB[WIDTH-1];
    mag_a  = a_neg ? -SrcA : SrcA;
    mag_b  = b_neg ? -SrcB : SrcB;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, b_q};
    div_shl = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_ge  = div_shl >= {1'b0, b_q};
    div_sub = div_shl - {1'b0, b_q};
    div_rem = WIDTH'(div_ge ? div_sub : div_shl);

    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d   = S_CALC;
          busy_d    = 1'b1;
          cnt_d     = '0;
          is_div_d  = MDOp[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (MDOp[1]) begin
            acc_d = {WIDTH'(0), mag_a};
            b_d   = mag_b;
          end else begin
            acc_d = {WIDTH'(0), mag_b};
            b_d   = mag_a;
          end
        end else begin
          if (HiWrite) hi_d = SrcA;
          if (LoWrite) lo_d = SrcA;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
        end else if (acc_q[0]) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[W2-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        // Divide by zero: quotient all ones, remainder restores to the raw dividend
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = (b_q == '0) ? '1 : quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus queues expected {Hi,Lo}; a monitor checks each Done.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic [31:0] SrcA, SrcB;
  logic        Start;
  logic [1:0]  MDOp;
  logic        HiWrite, LoWrite;
  logic [31:0] Hi, Lo;
  logic        Busy, Done;

  int          npass = 0;
  int          ntotal = 0;
  int          res_idx = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_hi, last_lo;
  logic        done_prev = 1'b0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .Start   (Start),
    .MDOp    (MDOp),
    .HiWrite (HiWrite),
    .LoWrite (LoWrite),
    .Hi      (Hi),
    .Lo      (Lo),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    ntotal++;
    if (act === expv) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Monitor: every Done pops one expected result
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset) begin
      done_prev = 1'b0;
    end else begin
      if (Done) begin
        chk("done_pulse_width", 64'(done_prev), 64'd0);
        if (exp_q.size() == 0) begin
          ntotal++;
          $display("FAIL unexpected_done: Hi=0x%0h Lo=0x%0h with no result pending", Hi, Lo);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("res%0d_hi", res_idx), 64'(Hi), 64'(e[63:32]));
          chk($sformatf("res%0d_lo", res_idx), 64'(Lo), 64'(e[31:0]));
          chk($sformatf("res%0d_busy_at_done", res_idx), 64'(Busy), 64'd0);
          res_idx++;
        end
      end
      done_prev = Done;
    end
  end

  // Issue one operation, count Busy cycles, optionally poke inputs while busy
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv, input logic hiwr, input logic disturb);
    int cnt;
    @(negedge clk);
    SrcA = a; SrcB = b; MDOp = op; Start = 1'b1; HiWrite = hiwr;
    exp_q.push_back(expv);
    @(negedge clk);
    Start = 1'b0; HiWrite = 1'b0;
    cnt = 0;
    while (Busy && cnt < 40) begin
      cnt++;
      if (cnt == 20) begin
        chk("hold_hi", 64'(Hi), 64'(last_hi));
        chk("hold_lo", 64'(Lo), 64'(last_lo));
      end
      if (disturb) begin
        case (cnt)
          2:  begin Start = 1'b1; MDOp = 2'b11; SrcA = 32'd9; SrcB = 32'd3; end
          3:  Start = 1'b0;
          5:  begin HiWrite = 1'b1; SrcA = 32'hDEADBEEF; end
          6:  HiWrite = 1'b0;
          10: begin SrcA = 32'hAAAAAAAA; SrcB = 32'h00012345; end
          33: begin Start = 1'b1; MDOp = 2'b11; SrcA = 32'd9; SrcB = 32'd3; end
          default: ;
        endcase
      end
      @(negedge clk);
    end
    Start = 1'b0; HiWrite = 1'b0;
    chk("busy_cycles", 64'(cnt), 64'd33);
    @(negedge clk);
    chk("done_low_after", 64'(Done), 64'd0);
    last_hi = expv[63:32];
    last_lo = expv[31:0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    SrcA = '0; SrcB = '0; MDOp = 2'b00;
    @(negedge clk);
    chk("rst_hi", 64'(Hi), 64'd0);
    chk("rst_lo", 64'(Lo), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // MTHI and MTLO together
    @(negedge clk);
    SrcA = 32'hA5A5A5A5; HiWrite = 1'b1; LoWrite = 1'b1;
    @(negedge clk);
    HiWrite = 1'b0; LoWrite = 1'b0;
    chk("mthi_hi", 64'(Hi), 64'hA5A5A5A5);
    chk("mtlo_lo", 64'(Lo), 64'hA5A5A5A5);
    chk("mt_done", 64'(Done), 64'd0);
    last_hi = 32'hA5A5A5A5; last_lo = 32'hA5A5A5A5;

    // Start with HiWrite: the write is dropped
    run_op(2'b01, 32'd2, 32'd3, 64'h00000000_00000006, 1'b1, 1'b0);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 1'b0);
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 1'b0);
    run_op(2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 1'b0);
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 1'b0);
    run_op(2'b10, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFFFFF0, 32'd0, 64'hFFFFFFF0_FFFFFFFF, 1'b0, 1'b0);
    run_op(2'b11, 32'd9, 32'd0, 64'h00000009_FFFFFFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 1'b0);
    // Start/HiWrite/operand changes while busy, and Start during FIX, are ignored
    run_op(2'b01, 32'd3, 32'd5, 64'h00000000_0000000F, 1'b0, 1'b1);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    SrcA = 32'hFFFFFFFF; SrcB = 32'd2; MDOp = 2'b01; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (11) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_hi", 64'(Hi), 64'd0);
    chk("async_rst_lo", 64'(Lo), 64'd0);
    chk("async_rst_busy", 64'(Busy), 64'd0);
    chk("async_rst_done", 64'(Done), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 64'(Busy), 64'd0);
    last_hi = 32'd0; last_lo = 32'd0;

    @(negedge clk);
    SrcA = 32'h55; LoWrite = 1'b1;
    @(negedge clk);
    LoWrite = 1'b0;
    chk("mtlo_after_rst_lo", 64'(Lo), 64'h55);
    chk("mtlo_after_rst_hi", 64'(Hi), 64'd0);
    chk("mtlo_after_rst_done", 64'(Done), 64'd0);
    last_lo = 32'h55;

    run_op(2'b01, 32'd6, 32'd7, 64'h00000000_0000002A, 1'b0, 1'b0);

    repeat (40) @(negedge clk);
    chk("pending_results", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
